// File: rtl/led_pattern_gen_if.sv
// Control/status bundle for led_pattern_gen: pattern select, prescaler divisor, pause,
// step strobe and LED bank. WIDTH/DIV_W must match the attached generator instance.
interface led_pattern_gen_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV_W = 24
);
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             pause;
    logic             step_o;
    logic [WIDTH-1:0] led;

    modport master (
        output mode, div, pause,
        input  step_o, led
    );

    modport slave (
        input  mode, div, pause,
        output step_o, led
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate / bounce / binary count / blink, advanced by a prescaler tick.
// Define LED_PATTERN_GEN_SYNC_EN to pass mode and pause through 2-flop synchronizers.
module led_pattern_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV_W = 24
) (
    input logic              clk,
    input logic              rst_key,
    led_pattern_gen_if.slave bus
);
    typedef enum logic {DirLeft, DirRight} dir_e;

    localparam logic [1:0]       ModeRotate = 2'd0;
    localparam logic [1:0]       ModeBounce = 2'd1;
    localparam logic [1:0]       ModeCount  = 2'd2;
    localparam logic [1:0]       ModeBlink  = 2'd3;
    localparam logic [WIDTH-1:0] LedOne     = WIDTH'(1);
    localparam logic [DIV_W-1:0] CntOne     = DIV_W'(1);

    logic [1:0] mode_s;
    logic       pause_s;

`ifdef LED_PATTERN_GEN_SYNC_EN
    logic [1:0] mode_m;
    logic       pause_m;

    always_ff @(posedge clk or negedge rst_key) begin
        if (!rst_key) begin
            mode_m  <= '0;
            mode_s  <= '0;
            pause_m <= 1'b0;
            pause_s <= 1'b0;
        end else begin
            mode_m  <= bus.mode;
            mode_s  <= mode_m;
            pause_m <= bus.pause;
            pause_s <= pause_m;
        end
    end
`else
    assign mode_s  = bus.mode;
    assign pause_s = bus.pause;
`endif

    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             step_q;

    logic mode_chg;
    logic tick;
    logic one_hot;

    assign mode_chg = (mode_s != mode_q);
    // >= rather than == so lowering div below cnt ticks at once instead of wrapping
    assign tick     = (cnt_q >= bus.div) && !pause_s && !mode_chg;
    assign one_hot  = (led_q != '0) && ((led_q & (led_q - LedOne)) == '0);

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        led_d  = led_q;
        if (mode_chg) begin
            mode_d = mode_s;
            cnt_d  = '0;
            dir_d  = DirLeft;
            led_d  = (mode_s == ModeRotate || mode_s == ModeBounce) ? LedOne : '0;
        end else if (pause_s) begin
            cnt_d = cnt_q;
        end else if (tick) begin
            cnt_d = '0;
            unique case (mode_q)
                ModeRotate: led_d = {led_q[WIDTH-2:0], ~|led_q[WIDTH-2:0]};
                ModeBounce: begin
                    if (!one_hot) begin
                        led_d = LedOne;
                        dir_d = DirLeft;
                    end else if (dir_q == DirLeft) begin
                        if (led_q[WIDTH-1]) begin
                            dir_d = DirRight;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DirLeft;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                ModeCount:  led_d = led_q + LedOne;
                ModeBlink:  led_d = (led_q == '0) ? '1 : '0;
                default:    led_d = led_q;
            endcase
        end else begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_key) begin
        if (!rst_key) begin
            mode_q <= ModeRotate;
            cnt_q  <= '0;
            dir_q  <= DirLeft;
            led_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= tick;
        end
    end

    assign bus.led    = led_q;
    assign bus.step_o = step_q;
endmodule
